// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Shared types for the iterative shift/rotate unit: FSM state,
//               operation kind and direction encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    // Controller states of the iterative shifter
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shstate_e;

    // Operation kind: zero-filling shift or circular rotate
    typedef enum logic {
        OP_SHIFT  = 1'b0,
        OP_ROTATE = 1'b1
    } shop_e;

    // Direction of the one-position move
    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } shdir_e;

endpackage : shifter_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational one-position shift or rotate, left or right.
//               Shifts fill the vacated bit with zero; rotates wrap the bit
//               that falls off one end back into the other.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  shop_e            op,
    input  shdir_e           dir,
    output logic [WIDTH-1:0] dout
);

    logic w_fill_left;   // bit entering at the LSB on a left move
    logic w_fill_right;  // bit entering at the MSB on a right move

    // Select the bit shifted in: the wrapped bit for a rotate, zero otherwise
    always_comb begin
        w_fill_left  = 1'b0;
        w_fill_right = 1'b0;
        if (op == OP_ROTATE) begin
            w_fill_left  = din[WIDTH-1];
            w_fill_right = din[0];
        end
    end

    // Move the operand by exactly one position in the requested direction
    always_comb begin
        dout = din;
        if (dir == DIR_LEFT) begin
            dout = {din[WIDTH-2:0], w_fill_left};
        end else begin
            dout = {w_fill_right, din[WIDTH-1:1]};
        end
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/iterative_shifter.sv
`default_nettype none
// ============================================================================
// Module      : iterative_shifter
// Description : Multi-cycle shift/rotate unit. Accepts an operand in IDLE,
//               moves it one bit per clock in SHIFT, then presents the result
//               in DONE until the consumer takes it. Valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               select,
    input  logic               direction,
    input  logic [SHAMT_W-1:0] shift_value,
    input  logic [WIDTH-1:0]   din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dout,
    output logic               busy
);

    localparam logic [SHAMT_W-1:0] C_COUNT_ONE  = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] C_COUNT_ZERO = '0;

    shstate_e           r_state;
    shstate_e           w_state_nxt;
    logic [SHAMT_W-1:0] r_count;
    logic [SHAMT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0]   r_dout;
    logic [WIDTH-1:0]   w_dout_nxt;
    shop_e              r_op;
    shop_e              w_op_nxt;
    shdir_e             r_dir;
    shdir_e             w_dir_nxt;
    logic [WIDTH-1:0]   w_step;

    // One-position move of the working register using the latched op and dir
    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .din  (r_dout),
        .op   (r_op),
        .dir  (r_dir),
        .dout (w_step)
    );

    // Registers: reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= C_COUNT_ZERO;
            r_dout  <= '0;
            r_op    <= OP_SHIFT;
            r_dir   <= DIR_RIGHT;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_dout  <= w_dout_nxt;
            r_op    <= w_op_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Next-state, count and datapath control; inputs are only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_dout_nxt  = r_dout;
        w_op_nxt    = r_op;
        w_dir_nxt   = r_dir;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_dout_nxt  = din;
                    w_op_nxt    = shop_e'(select);
                    w_dir_nxt   = shdir_e'(direction);
                    w_count_nxt = shift_value;
                    // A zero amount skips straight to presenting the operand
                    w_state_nxt = (shift_value == C_COUNT_ZERO) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_dout_nxt = w_step;
                // Guarded decrement so the counter can never wrap
                if (r_count != C_COUNT_ZERO) begin
                    w_count_nxt = r_count - C_COUNT_ONE;
                end
                if (r_count <= C_COUNT_ONE) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // Result held stable until the consumer accepts it
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs decode from state alone: no path from out_ready
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state == SHIFT) || (r_state == DONE);
        dout      = r_dout;
    end

endmodule : iterative_shifter
`default_nettype wire

// File: tb/tb_iterative_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_shifter
// Description : Scoreboard bench for iterative_shifter (WIDTH=8). A driver
//               issues directed then random operations and queues expected
//               results from an arithmetic reference model; a monitor pops
//               and compares results, latency and backpressure hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_shifter;

    localparam int WIDTH   = 8;
    localparam int SHAMT_W = 3;
    localparam int NDIR    = 6;
    localparam int NTXN    = 150;

    typedef struct {
        logic [WIDTH-1:0] exp;
        int               n;
        int               cyc;
    } sb_entry_t;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               select;
    logic               direction;
    logic [SHAMT_W-1:0] shift_value;
    logic [WIDTH-1:0]   din;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   dout;
    logic               busy;

    int        n_checks = 0;
    int        n_fail   = 0;
    int        cyc      = 0;
    int        issued   = 0;
    int        res_idx  = 0;
    bit        drv_en   = 0;
    bit        mon_en   = 0;
    sb_entry_t sb[$];

    // Directed table: select, direction, amount, operand, expected result
    logic [0:0]       d_sel [NDIR] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [0:0]       d_dir [NDIR] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int               d_n   [NDIR] = '{3, 5, 0, 0, 7, 7};
    logic [WIDTH-1:0] d_din [NDIR] = '{8'h96, 8'hF0, 8'h5A, 8'h5A, 8'hFF, 8'h01};
    logic [WIDTH-1:0] d_exp [NDIR] = '{8'hB4, 8'h07, 8'h5A, 8'h5A, 8'h80, 8'h02};

    iterative_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .select      (select),
        .direction   (direction),
        .shift_value (shift_value),
        .din         (din),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dout        (dout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole-operation reference: plain arithmetic on the operand
    function automatic logic [WIDTH-1:0] ref_model(input bit rot, input bit left,
                                                   input int n, input logic [WIDTH-1:0] d);
        logic [2*WIDTH-1:0] dd;
        dd = {d, d};
        if (!rot) return left ? WIDTH'(d << n) : WIDTH'(d >> n);
        if (left) begin
            dd = dd << n;
            return dd[2*WIDTH-1:WIDTH];
        end
        dd = dd >> n;
        return dd[WIDTH-1:0];
    endfunction

    // Driver: issue operations when idle, drive junk on the inputs while busy
    initial begin
        sb_entry_t e;
        bit        s;
        bit        dr;
        int        n;
        forever begin
            @(negedge clk);
            if (drv_en) begin
                if (in_ready && issued < NTXN && (issued < NDIR || $urandom_range(0, 3) != 0)) begin
                    if (issued < NDIR) begin
                        s = d_sel[issued][0];
                        dr = d_dir[issued][0];
                        n = d_n[issued];
                        din = d_din[issued];
                        e.exp = d_exp[issued];
                    end else begin
                        s = 1'($urandom);
                        dr = 1'($urandom);
                        n = $urandom_range(0, WIDTH - 1);
                        din = WIDTH'($urandom);
                        e.exp = ref_model(s, dr, n, din);
                    end
                    select      = s;
                    direction   = dr;
                    shift_value = SHAMT_W'(n);
                    in_valid    = 1'b1;
                    e.n   = n;
                    e.cyc = cyc;
                    sb.push_back(e);
                    issued++;
                end else begin
                    select      = 1'($urandom);
                    direction   = 1'($urandom);
                    shift_value = SHAMT_W'($urandom);
                    din         = WIDTH'($urandom);
                    in_valid    = in_ready ? 1'b0 : 1'($urandom);
                end
            end
        end
    end

    // Monitor: compare results, latency and stability under backpressure
    initial begin
        sb_entry_t        e;
        bit               holding   = 0;
        bit               just_hand = 0;
        int               hold_left = 0;
        logic [WIDTH-1:0] held;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (just_hand) begin
                    check("after_hand_out_valid", out_valid, 0);
                    check("after_hand_in_ready", in_ready, 1);
                    just_hand = 0;
                end
                if (out_valid) begin
                    if (!holding) begin
                        if (sb.size() == 0) begin
                            check("unexpected_result", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            check("result_dout", dout, e.exp);
                            check("latency", cyc - e.cyc, e.n + 1);
                        end
                        held = dout;
                        hold_left = (res_idx == 0) ? 3 :
                                    (($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
                        res_idx++;
                    end else begin
                        check("hold_dout", dout, held);
                        check("hold_in_ready", in_ready, 0);
                    end
                    if (hold_left > 0) begin
                        out_ready = 1'b0;
                        hold_left--;
                        holding = 1;
                    end else begin
                        out_ready = 1'b1;
                        holding = 0;
                        just_hand = 1;
                    end
                end else begin
                    if (holding) begin
                        check("valid_dropped", out_valid, 1);
                        holding = 0;
                    end
                    out_ready = 1'($urandom);
                end
            end
        end
    end

    // Sequencing: reset, scoreboard run, then mid-operation reset
    initial begin
        int  i;
        bit  seen;
        rst_n = 1'b0; in_valid = 1'b0; select = 1'b0; direction = 1'b0;
        shift_value = '0; din = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_dout", dout, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;

        drv_en = 1; mon_en = 1;
        for (i = 0; i < 20000; i++) begin
            @(negedge clk); #1;
            if (issued == NTXN && sb.size() == 0 && in_ready) break;
        end
        check("run_completed", (i < 20000) ? 1 : 0, 1);
        check("all_issued", issued, NTXN);
        drv_en = 0; mon_en = 0;

        // Start a left shift by 7, reset when three positions have been moved
        @(negedge clk);
        in_valid = 1'b1; select = 1'b0; direction = 1'b1; shift_value = 3'd7; din = 8'hAB;
        @(negedge clk);
        in_valid = 1'b0;
        check("midop_busy", busy, 1);
        repeat (3) @(negedge clk);
        check("midop_still_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_dout", dout, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("discarded_op_no_result", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_iterative_shifter
`default_nettype wire
